// File: rtl/spi_fifo_tx.sv
// rtl/spi_fifo_tx.sv - SPI mode-0 MSB-first transmitter draining a byte FIFO (option: SPI_FIFO_TX_BURST_EN)
module spi_fifo_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] buf_out,
    input  logic       buf_empty,
    output logic       rd_en,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       byte_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [6:0]       sh_q, sh_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             done_q, done_d;

    logic div_tc;
    logic last_fall;

    assign div_tc    = (div_q == DIV_LAST);
    assign last_fall = (state_q == S_SHIFT) && div_tc && sclk_q && (bit_q == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable && !buf_empty) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (last_fall) begin
`ifdef SPI_FIFO_TX_BURST_EN
                    // Chain straight into the next fetch so cs_n never rises mid-burst.
                    state_d = (enable && !buf_empty) ? S_FETCH : S_HOLD;
`else
                    state_d = S_HOLD;
`endif
                end
            end
            S_HOLD:  if (div_tc) state_d = S_GAP;
            S_GAP:   if (div_tc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d  = '0;
        bit_d  = bit_q;
        sh_d   = sh_q;
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_n_d = cs_n_q;
        done_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                sh_d   = buf_out[6:0];
                mosi_d = buf_out[7];
                cs_n_d = 1'b0;
                bit_d  = '0;
            end
            S_SHIFT: begin
                if (div_tc) begin
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        // Falling edge: advance to the next bit, or finish the byte holding the last one.
                        if (bit_q == 3'd7) begin
                            bit_d  = '0;
                            done_d = 1'b1;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            mosi_d = sh_q[6];
                            sh_d   = {sh_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (div_tc) cs_n_d = 1'b1;
                else        div_d  = div_q + DIV_W'(1);
            end
            S_GAP: begin
                if (!div_tc) div_d = div_q + DIV_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_en     = (state_q == S_FETCH);
        busy      = (state_q != S_IDLE);
        sclk      = sclk_q;
        mosi      = mosi_q;
        cs_n      = cs_n_q;
        byte_done = done_q;
    end

endmodule

// File: tb/tb_spi_fifo_tx.sv
// tb/tb_spi_fifo_tx.sv - scoreboard bench for spi_fifo_tx with CLK_DIV=2
module tb_spi_fifo_tx;

    localparam int K = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] buf_out = 8'h00;
    logic       buf_empty = 1'b1;
    logic       rd_en, sclk, mosi, cs_n, busy, byte_done;

    always #5 clk = ~clk;

    spi_fifo_tx #(.CLK_DIV(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .buf_out   (buf_out),
        .buf_empty (buf_empty),
        .rd_en     (rd_en),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .busy      (busy),
        .byte_done (byte_done)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit expect_tx);
        fifo.push_back(b);
        buf_empty = 1'b0;
        if (expect_tx) exp_q.push_back(b);
    endtask

    // FIFO model: data appears after the rd_en cycle, well before the LOAD edge samples it
    always @(negedge clk) begin
        if (rd_en) begin
            if (fifo.size() == 0) check("rd_en_on_empty", 1, 0);
            else buf_out = fifo.pop_front();
        end
        buf_empty = (fifo.size() == 0);
    end

    int   cyc = 0, t_rd = 0, t_done = 0, t_rise = 0;
    int   rises = 0, rd_cnt = 0, cs_falls = 0, nb = 0;
    logic [7:0] sh = 8'h00;
    logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_rd = 1'b0;
    bit   track_gap = 1'b0, rise_seen = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            nb = 0;
            rise_seen = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                rises++;
                sh = {sh[6:0], mosi};
                nb++;
            end
            if (byte_done) begin
                check("bits_per_byte", nb, 8);
                check("done_latency", cyc - t_rd, 2 + 16 * K);
                if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
                else check("byte_value", sh, exp_q.pop_front());
                nb = 0;
                t_done = cyc;
            end
            if (!cs_n && prev_cs) begin
                cs_falls++;
                check("cs_fall_after_rd", cyc - t_rd, 2);
            end
            if (cs_n && !prev_cs) begin
                check("cs_rise_after_done", cyc - t_done, K);
                t_rise = cyc;
                rise_seen = 1'b1;
            end
            if (rd_en) begin
                check("rd_single_cycle", prev_rd, 0);
                rd_cnt++;
                if (track_gap && rise_seen) check("idle_gap", cyc - t_rise, K + 1);
                rise_seen = 1'b0;
                t_rd = cyc;
            end
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        prev_rd   = rd_en;
    end

    task automatic wait_done(input int max);
        int i = 0;
        while ((exp_q.size() != 0 || busy) && i < max) begin
            @(negedge clk);
            i++;
        end
        check("wait_in_budget", (i < max), 1);
    endtask

    task automatic wait_rises(input int target, input int max);
        int i = 0;
        while (rises < target && i < max) begin
            @(negedge clk);
            i++;
        end
        check("rise_wait_in_budget", (i < max), 1);
    endtask

    initial begin
        int r0, rd0, f0, bad;
        // Reset held with enable and a non-empty FIFO
        enable = 1'b1;
        push(8'hA5, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {cs_n, sclk, mosi, rd_en, busy, byte_done}, 6'b100000);
        end
        check("reset_no_rd", rd_cnt, 0);
        rst = 1'b0;
        wait_done(500);
        check("single_rd_pulses", rd_cnt, 1);
        check("single_rises", rises, 8);
        check("single_frames", cs_falls, 1);

        // Three bytes back to back
        r0 = rises; rd0 = rd_cnt; f0 = cs_falls;
        track_gap = 1'b1;
        push(8'h01, 1'b1);
        push(8'h80, 1'b1);
        push(8'hFF, 1'b1);
        wait_done(1000);
        track_gap = 1'b0;
        check("three_rises", rises - r0, 24);
        check("three_rd", rd_cnt - rd0, 3);
`ifdef SPI_FIFO_TX_BURST_EN
        check("three_frames", cs_falls - f0, 1);
`else
        check("three_frames", cs_falls - f0, 3);
`endif

        // Empty FIFO with enable held high
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || rd_en || !cs_n) bad++;
        end
        check("empty_idle_violations", bad, 0);

        // enable dropped mid-byte
        r0 = rises; rd0 = rd_cnt;
        push(8'h3C, 1'b1);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        wait_rises(r0 + 3, 500);
        enable = 1'b0;
        wait_done(500);
        repeat (20) @(negedge clk);
        check("drop_fifo_left", fifo.size(), 2);
        check("drop_rd", rd_cnt - rd0, 1);
        check("drop_idle", busy, 0);

        // Reset pulse mid-byte discards 0x11; 0x22 follows cleanly
        exp_q.push_back(8'h22);
        r0 = rises;
        enable = 1'b1;
        wait_rises(r0 + 5, 500);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", {cs_n, sclk, busy}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        wait_done(500);
        check("rst_fifo_drained", fifo.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/spi_fifo_tx.md
# spi_fifo_tx

SPI mode-0 master transmitter that drains bytes from the byte FIFO and serialises them MSB-first on MOSI with a divided SCLK and an active-low chip select. It is the transmit-side counterpart of the SPI read collection path and attaches directly to the FIFO's read port: `rd_en` out, `buf_out` and `buf_empty` in. The FIFO delivers read data one cycle after `rd_en`. The block issues only single-cycle pops and only when the FIFO is non-empty.

## Interface
Parameters:
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles. Legal values are ≥ 1.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `enable`  in  1  permits new byte fetches; does not abort a byte in flight.
- `buf_out`  in  8  FIFO read data, valid the cycle after `rd_en`.
- `buf_empty`  in  1  FIFO empty flag.
- `rd_en`  out  1  single-cycle FIFO pop.
- `sclk`  out  1  SPI clock; idles low.
- `mosi`  out  1  serial data, MSB first.
- `cs_n`  out  1  chip select, active low.
- `busy`  out  1  high in every state except IDLE.
- `byte_done`  out  1  one-cycle pulse when a byte's 8th SCLK falling edge occurs.

## Operation
- Outputs on reset: `cs_n`=1, `sclk`=0, `mosi`=0, `rd_en`=0, `busy`=0, `byte_done`=0. State goes to IDLE and all counters clear.
- All outputs are registered or Moore decodes of the state register; no port-to-port combinational paths.
- State transitions:
  - IDLE: if `enable` && !`buf_empty` → FETCH.
  - FETCH (1 cycle): `rd_en`=1 → LOAD.
  - LOAD (1 cycle): shift register ← `buf_out`; `mosi` ← `buf_out[7]`; `cs_n` ← 0 → SHIFT.
  - SHIFT: half-period counter runs 0..`CLK_DIV`-1 and toggles `sclk` at terminal count.
    - On each falling edge, `mosi` takes the next bit.
    - After the 8th falling edge, `mosi` holds the last bit and `byte_done` pulses → NEXT.
  - NEXT (decision, 0 extra cycles): the burst rule applies (see Configuration); otherwise → HOLD.
  - HOLD (`CLK_DIV` cycles): `cs_n` stays 0, `sclk` stays 0 → GAP.
  - GAP (`CLK_DIV` cycles): `cs_n`=1 → IDLE.
- Bit counter is 3 bits and wraps 7→0 on byte completion. Half-period counter width is $clog2(`CLK_DIV`).
- Boundary conditions:
  - `buf_empty`=1 in IDLE: no `rd_en`, ever.
  - `enable` falls mid-byte: the current byte completes through HOLD/GAP, then the block stays in IDLE.
  - `rst` mid-byte: outputs take reset values at the next edge. The popped byte is discarded; no re-read.
  - `buf_empty` toggling during SHIFT: ignored.

## Timing
- `rd_en` in cycle T → LOAD in cycle T+1 → `cs_n` low and `mosi`=bit7 from cycle T+2.
- First `sclk` rise `CLK_DIV` cycles after `cs_n` falls. Each high/low phase lasts exactly `CLK_DIV` cycles.
- `byte_done` is asserted in the same cycle `sclk` returns low for the 8th time, i.e. 16·`CLK_DIV` cycles after `cs_n` falls.
- Non-burst byte-to-byte spacing: `cs_n` high for exactly `CLK_DIV` cycles, plus 1 IDLE cycle, before the next `rd_en`.
- Throughput: one byte per 16·`CLK_DIV`+2 cycles in burst mode. Non-burst adds 2·`CLK_DIV`+1 cycles per byte.

## Configuration
- Macro: `SPI_FIFO_TX_BURST_EN`.
- Defined: in NEXT, if `enable` && !`buf_empty` → FETCH directly.
  - `cs_n` stays low across bytes.
  - `sclk` low phase is extended by 2 cycles (FETCH + LOAD) between bytes.
  - Otherwise → HOLD.
- Undefined: NEXT always → HOLD → GAP. `cs_n` frames every byte individually.

## Test plan
- Reset values: hold `rst`=1 for 3 cycles with `enable`=1 and the FIFO non-empty → all outputs at reset values and `rd_en` never asserted.
- Single byte, `CLK_DIV`=2, FIFO holds 0xA5 →
  - exactly one `rd_en` pulse;
  - `cs_n` falls 2 cycles later;
  - `mosi` sampled on 8 `sclk` rises reads 1,0,1,0,0,1,0,1;
  - `byte_done` 32 cycles after `cs_n` falls;
  - `cs_n` rises 2 cycles after `byte_done`.
- Three bytes 0x01, 0x80, 0xFF with burst defined → `cs_n` low continuously and 24 rises total. With burst undefined → three separate `cs_n` frames with 2-cycle high gaps. Recovered bytes are identical in both builds.
- Empty FIFO with `enable`=1 for 100 cycles → `busy`=0, `rd_en`=0, `cs_n`=1 throughout.
- `enable` dropped after the 3rd `sclk` rise of 0x3C → full byte 0x3C transmitted, then IDLE with 2 bytes still in the FIFO.
- `rst` pulsed for 1 cycle after the 5th rise → next cycle `cs_n`=1, `sclk`=0, `busy`=0. With `enable`=1, the next FIFO byte transmits cleanly.
